// File: rtl/niosballe_key_capture_pkg.sv
// Shared constants for the key-capture port: register map and edge-select encodings.
package niosballe_key_capture_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_DATA    = 2'd0;
    localparam reg_addr_t ADDR_RSVD    = 2'd1;
    localparam reg_addr_t ADDR_IRQMASK = 2'd2;
    localparam reg_addr_t ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/niosballe_key_capture_if.sv
// Avalon-MM slave bus for the key-capture port, including its level interrupt.
interface niosballe_key_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/niosballe_debounce_bit.sv
// One key input: two-flop synchroniser followed by a consecutive-cycle debounce filter.
module niosballe_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic filt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg, sync2_reg;
    logic             filt_reg, filt_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // The counter only advances while the synchronised input disagrees with
    // the filtered value, so any agreement restarts the qualification window.
    always_comb begin
        filt_next = filt_reg;
        cnt_next  = '0;
        if (sync2_reg != filt_reg) begin
            if (cnt_reg == CNT_LAST) begin
                filt_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            filt_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            filt_reg  <= filt_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign filt = filt_reg;

endmodule

// File: rtl/niosballe_key_capture.sv
// Debounced key input port with per-bit edge capture and masked level IRQ on Avalon-MM.
module niosballe_key_capture
    import niosballe_key_capture_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_port,
    niosballe_key_capture_if.slave    bus
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d_reg;
    logic [WIDTH-1:0] irqmask_reg, irqmask_next;
    logic [WIDTH-1:0] ec_reg, ec_next;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic             wr;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        niosballe_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[gi]),
            .filt   (filt[gi])
        );
    end

    assign wr = bus.chipselect & ~bus.write_n;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: evt = ~filt & filt_d_reg;
            EDGE_ANY:  evt = filt ^ filt_d_reg;
            default:   evt = filt & ~filt_d_reg;
        endcase
    end

    // A fresh event overrides a same-cycle clear so no edge is ever lost.
    always_comb begin
        clr          = '0;
        irqmask_next = irqmask_reg;
        if (wr && bus.address == ADDR_EDGECAP) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        if (wr && bus.address == ADDR_IRQMASK) begin
            irqmask_next = bus.writedata[WIDTH-1:0];
        end
        ec_next = evt | (ec_reg & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d_reg  <= '0;
            irqmask_reg <= '0;
            ec_reg      <= '0;
        end else begin
            filt_d_reg  <= filt;
            irqmask_reg <= irqmask_next;
            ec_reg      <= ec_next;
        end
    end

    // Zero-wait-state read path; reads never alter state.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata[WIDTH-1:0] = filt;
            ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = ec_reg;
            default:      bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(ec_reg & irqmask_reg);

endmodule

// File: tb/tb_niosballe_key_capture.sv
// Directed bench: three instances (rising, falling, any edge) share keys, reset and bus strobes.
module tb_niosballe_key_capture;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [1:0]   bus_address;
    logic         bus_chipselect;
    logic         bus_write_n;
    logic [31:0]  bus_writedata;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    always #5 clk = ~clk;

    niosballe_key_capture_if if_rise ();
    niosballe_key_capture_if if_fall ();
    niosballe_key_capture_if if_any  ();

    assign if_rise.address = bus_address;  assign if_rise.chipselect = bus_chipselect;
    assign if_rise.write_n = bus_write_n;  assign if_rise.writedata  = bus_writedata;
    assign if_fall.address = bus_address;  assign if_fall.chipselect = bus_chipselect;
    assign if_fall.write_n = bus_write_n;  assign if_fall.writedata  = bus_writedata;
    assign if_any.address  = bus_address;  assign if_any.chipselect  = bus_chipselect;
    assign if_any.write_n  = bus_write_n;  assign if_any.writedata   = bus_writedata;

    niosballe_key_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(if_rise.slave));
    niosballe_key_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(if_fall.slave));
    niosballe_key_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(if_any.slave));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_address    = a;
        bus_writedata  = d;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        cyc(1);
        bus_chipselect = 1'b0;
        bus_write_n    = 1'b1;
    endtask

    task automatic set_addr(input logic [1:0] a);
        bus_address = a;
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 4'hF;
        bus_address    = 2'd0;
        bus_chipselect = 1'b0;
        bus_write_n    = 1'b1;
        bus_writedata  = '0;

        // Reset state with keys held high
        cyc(3);
        check_val("rst_irq", {31'd0, if_rise.irq}, 32'd0);
        set_addr(2'd0); check_val("rst_data", if_rise.readdata, 32'h0);
        set_addr(2'd2); check_val("rst_mask", if_rise.readdata, 32'h0);
        set_addr(2'd3); check_val("rst_ec",   if_rise.readdata, 32'h0);
        reset_n = 1'b1;
        set_addr(2'd0);
        cyc(5);         check_val("rel_data_e5", if_rise.readdata, 32'h0);
        cyc(1);         check_val("rel_data_e6", if_rise.readdata, 32'hF);
        cyc(1);
        set_addr(2'd3); check_val("rel_ec_rise", if_rise.readdata, 32'hF);
        check_val("rel_ec_fall", if_fall.readdata, 32'h0);
        check_val("rel_ec_any",  if_any.readdata,  32'hF);
        check_val("rel_irq", {31'd0, if_rise.irq}, 32'd0);
        bus_write(2'd3, 32'hF);
        set_addr(2'd3); check_val("clr_ec_rise", if_rise.readdata, 32'h0);
        in_port = 4'h0;
        cyc(7);
        check_val("fall_ec_fall", if_fall.readdata, 32'hF);
        check_val("fall_ec_rise", if_rise.readdata, 32'h0);
        bus_write(2'd3, 32'hF);

        // Glitch of 3 cycles must not pass
        in_port = 4'h1; cyc(3); in_port = 4'h0; cyc(10);
        set_addr(2'd0); check_val("glitch_data", if_rise.readdata, 32'h0);
        set_addr(2'd3); check_val("glitch_ec",   if_rise.readdata, 32'h0);
        check_val("glitch_ec_any", if_any.readdata, 32'h0);

        // 4-cycle hold passes: filt at edge 6, capture at edge 7
        in_port = 4'h1;
        set_addr(2'd0);
        cyc(5);         check_val("hold_data_e5", if_rise.readdata, 32'h0);
        cyc(1);         check_val("hold_data_e6", if_rise.readdata, 32'h1);
        set_addr(2'd3); check_val("hold_ec_e6",   if_rise.readdata, 32'h0);
        cyc(1);         check_val("hold_ec_e7",   if_rise.readdata, 32'h1);
        bus_write(2'd3, 32'hF);
        in_port = 4'h0; cyc(10); bus_write(2'd3, 32'hF);

        // IRQ path
        bus_write(2'd2, 32'h2);
        set_addr(2'd2); check_val("mask_rd", if_rise.readdata, 32'h2);
        in_port = 4'h3;
        set_addr(2'd3);
        cyc(6);         check_val("irq_pre", {31'd0, if_rise.irq}, 32'd0);
        cyc(1);         check_val("irq_ec", if_rise.readdata, 32'h3);
        check_val("irq_set", {31'd0, if_rise.irq}, 32'd1);
        bus_write(2'd3, 32'h2);
        set_addr(2'd3); check_val("irq_ec_clr", if_rise.readdata, 32'h1);
        check_val("irq_clr", {31'd0, if_rise.irq}, 32'd0);

        // Event and clear on the same edge: event wins
        in_port = 4'h0; cyc(10); bus_write(2'd3, 32'hF);
        in_port = 4'h1;
        cyc(6);
        bus_write(2'd3, 32'h1);
        set_addr(2'd3); check_val("simul_ec_rise", if_rise.readdata, 32'h1);
        check_val("simul_ec_any", if_any.readdata, 32'h1);
        bus_write(2'd3, 32'h1);
        set_addr(2'd3); check_val("simul_ec_after", if_rise.readdata, 32'h0);

        // Falling and any-edge behaviour with a clear between edges
        bus_write(2'd3, 32'hF);
        in_port = 4'h0; cyc(10);
        set_addr(2'd3);
        check_val("e10_fall", if_fall.readdata, 32'h1);
        check_val("e10_any",  if_any.readdata,  32'h1);
        check_val("e10_rise", if_rise.readdata, 32'h0);
        bus_write(2'd3, 32'hF);
        set_addr(2'd3); check_val("e01_any_clr", if_any.readdata, 32'h0);
        in_port = 4'h1; cyc(10);
        check_val("e01_any",  if_any.readdata,  32'h1);
        check_val("e01_fall", if_fall.readdata, 32'h0);
        check_val("e01_rise", if_rise.readdata, 32'h1);

        // Reset two cycles into a valid hold
        bus_write(2'd3, 32'hF);
        in_port = 4'h0; cyc(10); bus_write(2'd3, 32'hF);
        in_port = 4'h1;
        cyc(2);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            set_addr(2'd3); check_val($sformatf("mrst_ec_%0d", i), if_rise.readdata, 32'h0);
            set_addr(2'd0); check_val($sformatf("mrst_data_%0d", i), if_rise.readdata, 32'h0);
        end
        set_addr(2'd2); check_val("mrst_mask", if_rise.readdata, 32'h0);
        reset_n = 1'b1;
        set_addr(2'd0);
        cyc(5);         check_val("mrst_data_e5", if_rise.readdata, 32'h0);
        cyc(1);         check_val("mrst_data_e6", if_rise.readdata, 32'h1);
        set_addr(2'd3);
        cyc(1);         check_val("mrst_ec_e7", if_rise.readdata, 32'h1);
        cyc(5);
        bus_write(2'd3, 32'h1);
        cyc(10);
        set_addr(2'd3); check_val("mrst_single", if_rise.readdata, 32'h0);
        check_val("mrst_irq", {31'd0, if_rise.irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
